// File: rtl/score_collector_if.sv
// ----------------------------------------------------------------------------
// score_collector_if
// Bundles the score stream, the flush control and the argmax-side handshake of
// score_collector into one interface.
//   slave  modport : the collector's view (scores in, packed vector out)
//   master modport : the environment's view (upstream layer + argmax stage)
// Signals:
//   i_data/i_valid/o_ready       serial score input with backpressure
//   i_clear                      synchronous flush of a partial collection
//   i_sink_done                  completion pulse from the argmax stage
//   o_data/o_data_valid          packed vector and its 1-cycle strobe
//   o_count                      scores accepted into the current vector
//   o_timeout                    sink-timeout pulse (0 unless timeout enabled)
// ----------------------------------------------------------------------------
interface score_collector_if #(
    parameter int numInput   = 10,
    parameter int inputWidth = 16
);
    localparam int CountWidth = $clog2(numInput + 1);

    logic [inputWidth-1:0]          i_data;
    logic                           i_valid;
    logic                           o_ready;
    logic                           i_clear;
    logic                           i_sink_done;
    logic [numInput*inputWidth-1:0] o_data;
    logic                           o_data_valid;
    logic [CountWidth-1:0]          o_count;
    logic                           o_timeout;

    modport slave (
        input  i_data, i_valid, i_clear, i_sink_done,
        output o_ready, o_data, o_data_valid, o_count, o_timeout
    );

    modport master (
        output i_data, i_valid, i_clear, i_sink_done,
        input  o_ready, o_data, o_data_valid, o_count, o_timeout
    );
endinterface

// File: rtl/score_collector.sv
// ----------------------------------------------------------------------------
// score_collector
// Gathers numInput signed scores arriving one per accepted beat, packs them
// into a flat vector (slot k at [k*inputWidth +: inputWidth]) and hands the
// vector to the argmax stage with a single-cycle o_data_valid strobe. No new
// collection starts until the argmax stage reports completion on i_sink_done,
// so a running argmax search is never disturbed.
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      score_collector_if.slave (score stream, flush, sink handshake)
// Optional feature: define SCORE_SINK_TIMEOUT_EN to abandon WAIT_SINK after
// TIMEOUT_CYCLES cycles without i_sink_done (o_timeout pulses once). Without
// the macro WAIT_SINK waits indefinitely and o_timeout is tied low.
// ----------------------------------------------------------------------------
module score_collector #(
    parameter int numInput       = 10,
    parameter int inputWidth     = 16,
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic              i_clk,
    input logic              i_rst_n,
    score_collector_if.slave bus
);
    localparam int CW = $clog2(numInput + 1);
    localparam int VW = numInput * inputWidth;
    localparam logic [CW-1:0] LAST_SLOT = CW'(numInput - 1);

    typedef enum logic [1:0] {
        ST_COLLECT   = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_SINK = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [VW-1:0]   data_q, data_d;
    logic            data_valid_q, data_valid_d;
    logic            accept_s;
    logic            last_accept_s;
    logic            expire_s;
    logic            leave_wait_s;

    // i_clear outranks everything, so it also blocks the accept itself.
    assign accept_s      = bus.i_valid && (state_q == ST_COLLECT) && !bus.i_clear;
    assign last_accept_s = accept_s && (count_q == LAST_SLOT);

`ifdef SCORE_SINK_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] tmr_q, tmr_d;
    logic          timeout_q, timeout_d;

    // A done pulse on the expiry cycle wins over the timeout.
    assign expire_s = (state_q == ST_WAIT_SINK) && !bus.i_clear && !bus.i_sink_done &&
                      (tmr_q == TMR_LAST);

    // WAIT_SINK cycle counter; restarts from zero on every entry.
    always_comb begin
        tmr_d     = tmr_q;
        timeout_d = expire_s;
        if ((state_q == ST_WAIT_SINK) && (state_d == ST_WAIT_SINK)) begin
            tmr_d = tmr_q + TW'(1);
        end else begin
            tmr_d = '0;
        end
    end

    // Timeout counter and pulse registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tmr_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmr_q     <= tmr_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.o_timeout = timeout_q;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign expire_s      = 1'b0;
    assign bus.o_timeout = 1'b0;
`endif

    assign leave_wait_s = (state_q == ST_WAIT_SINK) && !bus.i_clear &&
                          (bus.i_sink_done || expire_s);

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        if (bus.i_clear) begin
            state_d = ST_COLLECT;
        end else begin
            case (state_q)
                ST_COLLECT: begin
                    if (last_accept_s) begin
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = ST_COLLECT;
                    end
                end
                ST_ISSUE: begin
                    state_d = ST_WAIT_SINK;
                end
                ST_WAIT_SINK: begin
                    if (leave_wait_s) begin
                        state_d = ST_COLLECT;
                    end else begin
                        state_d = ST_WAIT_SINK;
                    end
                end
                default: begin
                    state_d = ST_COLLECT;
                end
            endcase
        end
    end

    // FSM outputs: slot writes, accept counter and the issue strobe.
    always_comb begin
        count_d = count_q;
        data_d  = data_q;
        if (bus.i_clear || leave_wait_s) begin
            count_d = '0;
        end else if (accept_s) begin
            count_d = count_q + CW'(1);
        end else begin
            count_d = count_q;
        end
        // Slots are never zeroed; each one is rewritten before the next issue.
        for (int k = 0; k < numInput; k++) begin
            if (accept_s && (count_q == CW'(k))) begin
                data_d[k*inputWidth +: inputWidth] = bus.i_data;
            end else begin
                data_d[k*inputWidth +: inputWidth] = data_q[k*inputWidth +: inputWidth];
            end
        end
        // Strobe is high exactly during the single ISSUE cycle.
        data_valid_d = (state_d == ST_ISSUE);
    end

    // Datapath registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q      <= '0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
        end else begin
            count_q      <= count_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
        end
    end

    assign bus.o_ready      = (state_q == ST_COLLECT);
    assign bus.o_data       = data_q;
    assign bus.o_data_valid = data_valid_q;
    assign bus.o_count      = count_q;
endmodule

// File: tb/tb_score_collector.sv
// ----------------------------------------------------------------------------
// tb_score_collector
// Table-driven first vector, hand-written corner sequences (second vector,
// flush, mid-collection reset, sink timeout / indefinite wait) and a random
// phase, all checked against a queue-based reference model of the collector.
// ----------------------------------------------------------------------------
module tb_score_collector;
    localparam int N  = 10;
    localparam int W  = 16;
    localparam int T  = 16;
    localparam int VW = N * W;

    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b0;

    always #5 i_clk = ~i_clk;

    score_collector_if #(.numInput(N), .inputWidth(W)) bus ();

    score_collector #(.numInput(N), .inputWidth(W), .TIMEOUT_CYCLES(T)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: scores gathered so far, whether a vector is with the
    // sink, and the outputs expected after the most recent edge.
    logic [W-1:0]  m_q[$];
    logic          m_busy;
    logic          m_dv;
    logic          m_to;
    int            m_wait;
    logic [VW-1:0] m_vec;

    typedef struct {
        logic         v;
        logic [W-1:0] d;
        logic         c;
        logic         s;
        logic         e_ready;
        int           e_count;
        logic         e_dv;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [VW-1:0] pack_q();
        logic [VW-1:0] r = '0;
        for (int k = 0; k < m_q.size(); k++) r[k*W +: W] = m_q[k];
        return r;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_busy = 1'b0;
        m_dv   = 1'b0;
        m_to   = 1'b0;
        m_wait = 0;
        m_vec  = '0;
    endtask

    task automatic model_step(input logic v, input logic [W-1:0] d, input logic c, input logic s);
        logic strobe_pre;
        strobe_pre = m_dv;
        m_dv = 1'b0;
        m_to = 1'b0;
        if (c) begin
            m_q.delete();
            m_busy = 1'b0;
            m_wait = 0;
        end else if (!m_busy) begin
            if (v) begin
                m_q.push_back(d);
                if (m_q.size() == N) begin
                    m_busy = 1'b1;
                    m_dv   = 1'b1;
                    m_vec  = pack_q();
                    m_wait = 0;
                end
            end
        end else if (!strobe_pre) begin
            if (s) begin
                m_busy = 1'b0;
                m_q.delete();
            end
`ifdef SCORE_SINK_TIMEOUT_EN
            else begin
                m_wait++;
                if (m_wait == T) begin
                    m_to   = 1'b1;
                    m_busy = 1'b0;
                    m_q.delete();
                end
            end
`endif
        end
    endtask

    // Drive one cycle of inputs, update the model at the edge, return at the
    // following falling edge where outputs are sampled.
    task automatic drive_edge(input logic v, input logic [W-1:0] d, input logic c, input logic s);
        bus.i_valid     = v;
        bus.i_data      = d;
        bus.i_clear     = c;
        bus.i_sink_done = s;
        @(posedge i_clk);
        model_step(v, d, c, s);
        @(negedge i_clk);
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_ready"},   VW'(bus.o_ready),      VW'(!m_busy));
        chk({tag, "_count"},   VW'(bus.o_count),      VW'(m_q.size()));
        chk({tag, "_dv"},      VW'(bus.o_data_valid), VW'(m_dv));
        chk({tag, "_timeout"}, VW'(bus.o_timeout),    VW'(m_to));
        if (m_busy) chk({tag, "_data"}, bus.o_data, m_vec);
    endtask

    initial begin
        logic [VW-1:0] exp1;
        logic [VW-1:0] exp2;
        logic [VW-1:0] exp3;
        int            strobes;
        int            ready_seen;
        int            dv_at;
        int            to_at;

        bus.i_valid     = 1'b0;
        bus.i_data      = '0;
        bus.i_clear     = 1'b0;
        bus.i_sink_done = 1'b0;
        model_reset();

        for (int k = 0; k < N; k++) begin
            exp1[k*W +: W] = W'(k + 1);
            exp2[k*W +: W] = W'(16'hFFF6 + k);
            exp3[k*W +: W] = W'(16'h0100 + k);
        end

        // Reset values while reset is held.
        #1;
        chk("rst_ready",   VW'(bus.o_ready),      VW'(1));
        chk("rst_count",   VW'(bus.o_count),      VW'(0));
        chk("rst_dv",      VW'(bus.o_data_valid), VW'(0));
        chk("rst_data",    bus.o_data,            VW'(0));
        chk("rst_timeout", VW'(bus.o_timeout),    VW'(0));
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Table: 0x0001..0x000A, ISSUE->WAIT, dropped 0x7FFF, sink done, stray done.
        for (int k = 0; k < N; k++)
            tbl[k] = '{1'b1, W'(k + 1), 1'b0, 1'b0, (k < N - 1), k + 1, (k == N - 1)};
        tbl[10] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 10, 1'b0};
        tbl[11] = '{1'b1, 16'h7FFF, 1'b0, 1'b0, 1'b0, 10, 1'b0};
        tbl[12] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 0,  1'b0};
        tbl[13] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 0,  1'b0};
        for (int i = 0; i < 14; i++) begin
            drive_edge(tbl[i].v, tbl[i].d, tbl[i].c, tbl[i].s);
            chk("tbl_ready", VW'(bus.o_ready),      VW'(tbl[i].e_ready));
            chk("tbl_count", VW'(bus.o_count),      VW'(tbl[i].e_count));
            chk("tbl_dv",    VW'(bus.o_data_valid), VW'(tbl[i].e_dv));
            if (i == 9 || i == 11) chk("vec1_data", bus.o_data, exp1);
        end

        // Second vector 0xFFF6..0xFFFF, sink answers 11 cycles after the strobe.
        for (int k = 0; k < N; k++) begin
            drive_edge(1'b1, W'(16'hFFF6 + k), 1'b0, 1'b0);
            check_model("vec2");
        end
        chk("vec2_dv",   VW'(bus.o_data_valid), VW'(1));
        chk("vec2_data", bus.o_data, exp2);
        for (int k = 0; k < 10; k++) begin
            drive_edge(1'b0, '0, 1'b0, 1'b0);
            check_model("vec2_wait");
        end
        drive_edge(1'b0, '0, 1'b0, 1'b1);
        chk("vec2_ready_after_done", VW'(bus.o_ready), VW'(1));
        chk("vec2_count_after_done", VW'(bus.o_count), VW'(0));

        // Four scores, flush, then 0x0100..0x0109 must issue exactly once.
        for (int k = 0; k < 4; k++) drive_edge(1'b1, W'($urandom), 1'b0, 1'b0);
        drive_edge(1'b1, 16'h5555, 1'b1, 1'b0);
        check_model("clear");
        chk("clear_count", VW'(bus.o_count), VW'(0));
        strobes = 0;
        for (int k = 0; k < N + 3; k++) begin
            drive_edge((k < N), W'(16'h0100 + k), 1'b0, 1'b0);
            check_model("clr_vec");
            if (bus.o_data_valid) begin
                strobes++;
                chk("clr_vec_data", bus.o_data, exp3);
            end
        end
        chk("clr_vec_strobes", VW'(strobes), VW'(1));
        drive_edge(1'b0, '0, 1'b0, 1'b1);
        check_model("clr_done");

        // Reset at o_count=6 takes effect without a clock edge.
        for (int k = 0; k < 6; k++) drive_edge(1'b1, W'($urandom), 1'b0, 1'b0);
        chk("pre_rst_count", VW'(bus.o_count), VW'(6));
        bus.i_valid = 1'b0;
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("async_rst_ready", VW'(bus.o_ready),      VW'(1));
        chk("async_rst_count", VW'(bus.o_count),      VW'(0));
        chk("async_rst_dv",    VW'(bus.o_data_valid), VW'(0));
        chk("async_rst_data",  bus.o_data,            VW'(0));
        model_reset();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        strobes = 0;
        for (int k = 0; k < N + 2; k++) begin
            drive_edge((k < N), W'($urandom), 1'b0, 1'b0);
            check_model("post_rst");
            if (bus.o_data_valid) strobes++;
        end
        chk("post_rst_strobes", VW'(strobes), VW'(1));

        // Sink never answers.
`ifdef SCORE_SINK_TIMEOUT_EN
        dv_at = -1;
        to_at = -1;
        drive_edge(1'b0, '0, 1'b1, 1'b0);
        for (int k = 0; k < N + 25; k++) begin
            drive_edge((k < N), W'($urandom), 1'b0, 1'b0);
            check_model("tmo");
            if (bus.o_data_valid && dv_at < 0) dv_at = k;
            if (bus.o_timeout && to_at < 0) begin
                to_at = k;
                chk("tmo_ready", VW'(bus.o_ready), VW'(1));
            end
        end
        chk("tmo_delay", VW'(to_at - dv_at), VW'(T + 1));
`else
        dv_at = 0;
        to_at = 0;
        ready_seen = 0;
        for (int k = 0; k < 100; k++) begin
            drive_edge(1'b0, '0, 1'b0, 1'b0);
            check_model("nowait");
            if (bus.o_ready) ready_seen++;
        end
        chk("nowait_ready_stays_low", VW'(ready_seen + dv_at + to_at), VW'(0));
        drive_edge(1'b0, '0, 1'b0, 1'b1);
        check_model("nowait_done");
`endif

        // Random traffic against the model.
        for (int k = 0; k < 800; k++) begin
            drive_edge(($urandom_range(0, 99) < 70), W'($urandom),
                       ($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 15));
            check_model("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
